// File: rtl/maze_grid_mem.sv
// Maze occupancy store: one wall bit per cell, H-cycle clear sweep, row load,
// single-cell write, and a registered read of a cell plus its N/E/S/W neighbours.
module maze_grid_mem #(
    parameter int W  = 16,
    parameter int H  = 16,
    parameter int XW = 4,
    parameter int YW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr_req,
    output logic          busy,
    input  logic          load_valid,
    input  logic [YW-1:0] load_row,
    input  logic [W-1:0]  load_data,
    input  logic          wr_en,
    input  logic [XW-1:0] wr_x,
    input  logic [YW-1:0] wr_y,
    input  logic          wr_data,
    input  logic          rd_req,
    input  logic [XW-1:0] rd_x,
    input  logic [YW-1:0] rd_y,
    output logic          rd_valid,
    output logic          rd_cell,
    output logic [3:0]    rd_nbr
);
    typedef enum logic {ST_IDLE = 1'b0, ST_CLEAR = 1'b1} state_e;

    state_e        state_q, state_d;
    logic [YW-1:0] row_cnt_q, row_cnt_d;
    logic          busy_q, busy_d;
    logic [W-1:0]  mem_q [H];
    logic [W-1:0]  mem_d [H];
    logic          rd_valid_q, rd_valid_d;
    logic          rd_cell_q, rd_cell_d;
    logic [3:0]    rd_nbr_q, rd_nbr_d;

    // One extra bit lets x-1 at x=0 and x+1 at the last column land past the edge.
    logic [XW:0] rd_x_e;
    logic [YW:0] rd_y_e;
    assign rd_x_e = {1'b0, rd_x};
    assign rd_y_e = {1'b0, rd_y};

    function automatic logic cell_at(input logic [XW:0] x, input logic [YW:0] y);
        logic v;
        v = 1'b1;
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                if (int'(y) == r && int'(x) == c) v = mem_q[r][c];
            end
        end
        return v;
    endfunction

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
        state_d    = state_q;
        row_cnt_d  = row_cnt_q;
        busy_d     = busy_q;
        mem_d      = mem_q;
        rd_valid_d = 1'b0;
        rd_cell_d  = rd_cell_q;
        rd_nbr_d   = rd_nbr_q;

        unique case (state_q)
            ST_IDLE: begin
                // Row indices outside 0..H-1 (and columns outside 0..W-1) never match, so they drop.
                for (int r = 0; r < H; r++) begin
                    if (load_valid) begin
                        if (int'(load_row) == r) mem_d[r] = load_data;
                    end else if (wr_en && int'(wr_y) == r) begin
                        for (int c = 0; c < W; c++) begin
                            if (int'(wr_x) == c) mem_d[r][c] = wr_data;
                        end
                    end
                end
                if (clr_req) begin
                    state_d   = ST_CLEAR;
                    row_cnt_d = '0;
                    busy_d    = 1'b1;
                end
            end
            ST_CLEAR: begin
                for (int r = 0; r < H; r++) begin
                    if (int'(row_cnt_q) == r) mem_d[r] = '0;
                end
                if (clr_req) begin
                    row_cnt_d = '0;
                end else if (int'(row_cnt_q) == H - 1) begin
                    state_d   = ST_IDLE;
                    row_cnt_d = '0;
                    busy_d    = 1'b0;
                end else begin
                    row_cnt_d = row_cnt_q + YW'(1);
                end
            end
            default: ;
        endcase

        // Reads see mem_q, i.e. the contents before any write taking effect this edge.
        if (rd_req) begin
            rd_valid_d = 1'b1;
            if (int'(rd_x) >= W || int'(rd_y) >= H) begin
                rd_cell_d = 1'b1;
                rd_nbr_d  = 4'b1111;
            end else begin
                rd_cell_d = cell_at(rd_x_e, rd_y_e);
                rd_nbr_d  = {cell_at(rd_x_e, rd_y_e - (YW+1)'(1)),
                             cell_at(rd_x_e + (XW+1)'(1), rd_y_e),
                             cell_at(rd_x_e, rd_y_e + (YW+1)'(1)),
                             cell_at(rd_x_e - (XW+1)'(1), rd_y_e)};
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_CLEAR;
            row_cnt_q  <= '0;
            busy_q     <= 1'b1;
            rd_valid_q <= 1'b0;
            rd_cell_q  <= 1'b0;
            rd_nbr_q   <= '0;
        end else begin
            state_q    <= state_d;
            row_cnt_q  <= row_cnt_d;
            busy_q     <= busy_d;
            rd_valid_q <= rd_valid_d;
            rd_cell_q  <= rd_cell_d;
            rd_nbr_q   <= rd_nbr_d;
        end
        // NOTE: the array has no reset term; the post-reset clear sweep initialises it.
        mem_q <= mem_d;
    end

    assign busy     = busy_q;
    assign rd_valid = rd_valid_q;
    assign rd_cell  = rd_cell_q;
    assign rd_nbr   = rd_nbr_q;
endmodule

// File: doc/maze_grid_mem.md
# maze_grid_mem

Parametrised W×H maze occupancy store for the rat-in-maze datapath, replacing the fixed 16×16 bit map. Holds one bit per cell (1 = wall, 0 = open) and supports a multi-cycle clear sweep, whole-row loading from the map loader, single-cell writes, and a registered read returning the addressed cell plus its four neighbours in one access. It sits between the map loader and the rat controller FSM. Out-of-maze positions always read as walls.

## Interface
- `W`, 16, maze columns (x dimension), 2..64
- `H`, 16, maze rows (y dimension), 2..64
- `XW`, 4, x address width, ≥ clog2(W)
- `YW`, 4, y address width, ≥ clog2(H)

- `clk` in 1 — single clock, all logic on rising edge
- `rst` in 1 — synchronous, active-high reset
- `clr_req` in 1 — start clear sweep (pulse)
- `busy` out 1 — clear sweep in progress
- `load_valid` in 1 — write `load_data` to row `load_row`
- `load_row` in YW — row index for load
- `load_data` in W — row contents; bit i = cell x=i
- `wr_en` in 1 — single-cell write
- `wr_x` in XW, `wr_y` in YW — write address
- `wr_data` in 1 — cell value
- `rd_req` in 1 — read request
- `rd_x` in XW, `rd_y` in YW — read address
- `rd_valid` out 1 — read result valid
- `rd_cell` out 1 — addressed cell
- `rd_nbr` out 4 — neighbours {N,E,S,W}; N = y-1, E = x+1, S = y+1, W = x-1

## Operation
- Storage: H×W flop array; neighbour reads need parallel access.
- States: IDLE, CLEAR. `rst` forces CLEAR with row counter = 0.
- CLEAR: each cycle, zero row `row_cnt` and increment. Leave to IDLE after row H-1. Takes exactly H cycles; `busy` = 1 throughout.
- `clr_req` in IDLE enters CLEAR at row 0. `clr_req` during CLEAR restarts the sweep at row 0.
- Write priority in IDLE: `load_valid` > `wr_en`. If both are asserted, the load wins and the cell write is dropped.
- During CLEAR, `load_valid` and `wr_en` are ignored. No queuing.
- Out-of-range writes are ignored: `load_row` ≥ H, or `wr_x` ≥ W / `wr_y` ≥ H.
- Reads are accepted in any state, including CLEAR. They return array contents before any same-cycle write (read-before-write).
- Out-of-range handling:
  - Read address outside the maze: `rd_cell` = 1 and `rd_nbr` = 4'b1111.
  - Neighbour outside the maze (x=0 W, x=W-1 E, y=0 N, y=H-1 S): that neighbour bit reads 1.
- Neighbour index arithmetic is done at XW+1/YW+1 bits. No wrap-around: x=0 west is a wall, not column W-1.

## Timing
- Reset values: `busy` = 1 on the cycle after `rst` is sampled high; `rd_valid` = 0, `rd_cell` = 0, `rd_nbr` = 0.
- Array contents are undefined until the post-reset sweep ends, H cycles after `rst` falls. `rst` held high keeps the counter at 0.
- Read latency is 1 cycle: `rd_req` sampled at edge n gives `rd_valid` = 1 with data after edge n.
- `rd_valid` is high for exactly one cycle per request. Back-to-back requests give back-to-back results.
- Outputs hold their last data when `rd_valid` = 0.
- A write at edge n is visible to a read sampled at edge n+1.
- Reset mid-sweep or mid-read: the sweep restarts, and the pending `rd_valid` is squashed to 0.
- `busy` falls on the cycle after row H-1 is cleared. Loads and writes are accepted from that cycle.

## Test plan
- Reset with W=H=16: `rst` high for 2 cycles, then low. Expect `busy` high for 16 cycles, then 0. Then read (5,5): expect `rd_cell` = 0 and `rd_nbr` = 0000 after 1 cycle.
- Row load and neighbours:
  - Stimulus: load row 3 = 16'h00F0, then read (5,2).
  - Expect: `rd_cell` = 0, `rd_nbr` = 0010 (S wall only).
  - Stimulus: read (4,3).
  - Expect: `rd_cell` = 1, E = 1, W = 0.
- Boundaries:
  - Read (0,0) on a clear maze: expect `rd_nbr` = 1001 (N and W walls).
  - Read (15,15): expect 0110.
  - Read (x=15, y=20) with YW=5: expect `rd_cell` = 1, `rd_nbr` = 1111.
- Collisions:
  - Same cycle `load_valid` (row 2 = 16'hFFFF) and `wr_en` (2,2,0): expect row 2 all 1s.
  - Write (7,7,1) and read (7,7) in the same cycle: expect 0, then a read next cycle returns 1.
- Clear under activity:
  - Stimulus: `clr_req` with walls present, then `wr_en` during `busy`.
  - Expect: the write is ignored; all reads return 0 after the H-cycle sweep.
  - Stimulus: `clr_req` re-pulsed at sweep row 8.
  - Expect: `busy` extends to 16 cycles from the re-pulse.
- Reset mid-read: `rd_req` at edge n, `rst` at edge n → `rd_valid` stays 0 and the sweep restarts.
